constraint_checker: RTL and testbench
=====================================

Name: constraint_checker

Overview:
- Sudoku legality checker for a single placement. It decides whether a digit may be written into a given cell of a 9x9 board without repeating that digit in the cell's row, column or 3x3 box.
- Sits between the solver's search/backtrack controller and the board register file.
- Pure check: it never modifies the board.
- Result is registered with one-cycle latency.

Parameters:
- N, 9: board side length; fixed, only 9 is supported.
- CELL_W, 4: bits per cell.
- BOARD_W, N*N*CELL_W = 324: flattened board width.

Ports:
- clk  input  1  sole clock; everything samples on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_vld  input  1  request strobe; inputs are sampled when high.
- num_to_place  input  4  candidate digit; legal range 1..9.
- cell_index  input  7  target cell, row-major index r*9+c; legal range 0..80.
- board_flat  input  324  board contents; cell i occupies bits [4*i +: 4]; value 0 means empty, 1..9 means filled.
- out_vld  output  1  high for exactly one cycle, the cycle after an accepted request.
- valid  output  1  placement is legal; meaningful only while out_vld is high.

Behaviour:
- Address decode:
  - row = cell_index / 9, col = cell_index % 9.
  - Box origin = (3*(row/3), 3*(col/3)).
- Row conflict: any cell (row, c) with c != col holds num_to_place.
- Column conflict: any cell (r, col) with r != row holds num_to_place.
- Box conflict: any of the 8 other cells in the box holds num_to_place.
- Target cell: its own current content is ignored, so an overwrite check is allowed.
- Result: valid = no row, column or box conflict, AND num_to_place is in 1..9, AND cell_index <= 80.
  - num_to_place = 0 or 10..15 gives valid = 0.
  - Out-of-range cell_index gives valid = 0, with no out-of-range bit-select.
- Empty cells (value 0) never conflict. Values 10..15 on the board are compared literally, so they cannot match a legal digit.
- Timing:
  - The check logic is combinational from the inputs.
  - When in_vld is high at edge k, valid and out_vld are registered at edge k.
  - out_vld = 1 during cycle k+1 and returns to 0 unless a new request arrives.
  - Back-to-back requests are accepted every cycle; throughput is one check per clock.
  - There is no backpressure.
- When in_vld is low, valid holds its last value and out_vld = 0.
- Reset:
  - While rst is high at an edge: valid = 0, out_vld = 0, and any simultaneous request is dropped.
  - A request in flight when reset asserts is discarded.
- Inputs need only be stable around the sampling edge; nothing is held internally beyond the output registers.

Optional Feature:
- Macro CC_CONFLICT_MASK_EN.
- Defined: adds three outputs, row_conflict, col_conflict and box_conflict (1 bit each).
  - Registered alongside valid with the same timing.
  - Reset to 0.
  - Each is forced to 0 when num_to_place or cell_index is out of range.
- Undefined: these ports and their registers do not exist. valid and out_vld behaviour is identical in both builds.

Decomposition:
- Shared package sudoku_pkg:
  - Constants N=9, BOX=3, CELL_W=4, NCELLS=81, BOARD_W=324, DIGIT_MIN=1, DIGIT_MAX=9.
  - Types for cell value (4b), cell index (7b), and row/column (4b).
  - Used by the solver, board store and this block.
- One sub-module, cell_locator: combinational, maps cell_index to row, col, box_row0, box_col0 and an in_range flag. It is reused by the solver controller.
- Row, column and box scans are generate loops inside constraint_checker.

Test Plan:
- All-zero board, num=5, idx=0, in_vld pulse → next cycle out_vld=1, valid=1.
- Cell 3 (row 0) = 5, num=5, idx=0 → valid=0; with the macro enabled, row_conflict=1.
- All-zero board except cell 18 (col 0, row 2) = 5, num=5, idx=0 → valid=0; col_conflict=1.
- All-zero board except cell 10 (row 1, col 1, same box) = 5, num=5, idx=0 → valid=0; box_conflict=1.
- Target cell 0 = 5, all other cells empty, num=5, idx=0 → valid=1. Cell 80 = 7, num=7, idx=40 (different box) → valid=1.
- Boundary and control cases:
  - num=0 → valid=0.
  - num=10 → valid=0.
  - idx=81 → valid=0.
  - Back-to-back requests on consecutive cycles give matching consecutive results.
  - rst asserted together with in_vld → out_vld=0 and valid=0 on the following cycle.

Source files
------------

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: board geometry constants and cell/index types shared by solver, board store and checker
package sudoku_pkg;
    localparam int N         = 9;
    localparam int BOX       = 3;
    localparam int CELL_W    = 4;
    localparam int NCELLS    = N * N;
    localparam int BOARD_W   = NCELLS * CELL_W;
    localparam int DIGIT_MIN = 1;
    localparam int DIGIT_MAX = 9;
    typedef logic [CELL_W-1:0] cell_t;
    typedef logic [6:0]        idx_t;
    typedef logic [3:0]        rc_t;
endpackage

// File: rtl/cell_locator.sv
// cell_locator: decodes a row-major cell index into row, column, box origin and a range flag
module cell_locator
    import sudoku_pkg::*;
(
    input  logic [6:0] cell_index,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] box_row0,
    output logic [3:0] box_col0,
    output logic       in_range
);
    idx_t quo;
    idx_t rem;
    // divide by 9 for row/col, then snap each to the top-left of its 3x3 box
    always_comb begin
        quo      = cell_index / 7'(N);
        rem      = cell_index % 7'(N);
        row      = quo[3:0];
        col      = rem[3:0];
        box_row0 = (row / 4'(BOX)) * 4'(BOX);
        box_col0 = (col / 4'(BOX)) * 4'(BOX);
        in_range = cell_index <= 7'(NCELLS - 1);
    end
endmodule

// File: rtl/constraint_checker.sv
// constraint_checker: registered Sudoku placement legality check; CC_CONFLICT_MASK_EN adds per-unit conflict outputs
module constraint_checker
    import sudoku_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic [3:0]         num_to_place,
    input  logic [6:0]         cell_index,
    input  logic [BOARD_W-1:0] board_flat,
`ifdef CC_CONFLICT_MASK_EN
    output logic               row_conflict,
    output logic               col_conflict,
    output logic               box_conflict,
`endif
    output logic               out_vld,
    output logic               valid
);
    rc_t row, col, box_row0, box_col0;
    logic in_range;
    logic [NCELLS-1:0] row_hit, col_hit, box_hit;
    logic ok, row_any, col_any, box_any;

    cell_locator u_loc (
        .cell_index(cell_index),
        .row(row),
        .col(col),
        .box_row0(box_row0),
        .box_col0(box_col0),
        .in_range(in_range)
    );

    // every board cell is tested against the target's row/column/box using its fixed coordinates,
    // so no select is ever computed from cell_index and an out-of-range index cannot over-index the board
    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        localparam int R = i / N;
        localparam int C = i % N;
        logic hit;
        assign hit        = board_flat[CELL_W*i +: CELL_W] == num_to_place && cell_index != 7'(i);
        assign row_hit[i] = hit && row == 4'(R);
        assign col_hit[i] = hit && col == 4'(C);
        assign box_hit[i] = hit && box_row0 == 4'(R / BOX * BOX) && box_col0 == 4'(C / BOX * BOX);
    end

    assign ok      = in_range && num_to_place >= 4'(DIGIT_MIN) && num_to_place <= 4'(DIGIT_MAX);
    assign row_any = ok && |row_hit;
    assign col_any = ok && |col_hit;
    assign box_any = ok && |box_hit;

    // result registers: strobe each accepted request, hold the verdict between requests
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            valid   <= 1'b0;
`ifdef CC_CONFLICT_MASK_EN
            row_conflict <= 1'b0;
            col_conflict <= 1'b0;
            box_conflict <= 1'b0;
`endif
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                valid <= ok && !(row_any || col_any || box_any);
`ifdef CC_CONFLICT_MASK_EN
                row_conflict <= row_any;
                col_conflict <= col_any;
                box_conflict <= box_any;
`endif
            end
        end
    end
endmodule

// File: tb/tb_constraint_checker.sv
// tb_constraint_checker: directed and random placement checks against a row/column/box reference model
module tb_constraint_checker;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic [3:0]   num_to_place = 4'd0;
    logic [6:0]   cell_index = 7'd0;
    logic [323:0] board_flat = '0;
    logic         out_vld, valid;
`ifdef CC_CONFLICT_MASK_EN
    logic         row_conflict, col_conflict, box_conflict;
`endif

    logic [3:0] bd [81];
    logic exp_vld = 1'b0, exp_valid = 1'b0, exp_rc = 1'b0, exp_cc = 1'b0, exp_bc = 1'b0;
    int vectors = 0;
    int errs = 0;
    int stepno = 0;

    always #5 clk = ~clk;

    constraint_checker dut (
        .clk(clk),
        .rst(rst),
        .in_vld(in_vld),
        .num_to_place(num_to_place),
        .cell_index(cell_index),
        .board_flat(board_flat),
`ifdef CC_CONFLICT_MASK_EN
        .row_conflict(row_conflict),
        .col_conflict(col_conflict),
        .box_conflict(box_conflict),
`endif
        .out_vld(out_vld),
        .valid(valid)
    );

    task automatic check(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL step %0d %s observed=%b expected=%b", stepno, tag, obs, expv);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 81; i++) bd[i] = 4'd0;
    endtask

    // reference: walk the row, column and 3x3 box of the target with 2-D coordinates
    task automatic model(input int num, input int idx);
        int r, c, br, bc;
        bit rc, cc, bxc, ok;
        rc = 0; cc = 0; bxc = 0;
        ok = (num >= 1) && (num <= 9) && (idx <= 80);
        if (ok) begin
            r = idx / 9; c = idx % 9;
            br = (r / 3) * 3; bc = (c / 3) * 3;
            for (int k = 0; k < 9; k++) begin
                if (k != c && int'(bd[r*9+k]) == num) rc = 1;
                if (k != r && int'(bd[k*9+c]) == num) cc = 1;
            end
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    if (!(br+dr == r && bc+dc == c) && int'(bd[(br+dr)*9+bc+dc]) == num) bxc = 1;
        end
        exp_valid = ok && !rc && !cc && !bxc;
        exp_rc = rc; exp_cc = cc; exp_bc = bxc;
    endtask

    task automatic step(input logic [3:0] num, input logic [6:0] idx, input logic vld, input logic r);
        stepno++;
        rst = r; in_vld = vld; num_to_place = num; cell_index = idx;
        for (int i = 0; i < 81; i++) board_flat[4*i +: 4] = bd[i];
        if (r) begin
            exp_vld = 0; exp_valid = 0; exp_rc = 0; exp_cc = 0; exp_bc = 0;
        end else begin
            exp_vld = vld;
            if (vld) model(int'(num), int'(idx));
        end
        @(posedge clk);
        #1;
        check("out_vld", out_vld, exp_vld);
        check("valid", valid, exp_valid);
`ifdef CC_CONFLICT_MASK_EN
        check("row_conflict", row_conflict, exp_rc);
        check("col_conflict", col_conflict, exp_cc);
        check("box_conflict", box_conflict, exp_bc);
`endif
    endtask

    initial begin
        clear_board();
        step(4'd0, 7'd0, 1'b0, 1'b1);
        step(4'd5, 7'd0, 1'b1, 1'b1);
        step(4'd5, 7'd0, 1'b1, 1'b0);
        bd[3] = 4'd5;
        step(4'd5, 7'd0, 1'b1, 1'b0);
        clear_board(); bd[18] = 4'd5;
        step(4'd5, 7'd0, 1'b1, 1'b0);
        clear_board(); bd[10] = 4'd5;
        step(4'd5, 7'd0, 1'b1, 1'b0);
        clear_board(); bd[0] = 4'd5;
        step(4'd5, 7'd0, 1'b1, 1'b0);
        clear_board(); bd[80] = 4'd7;
        step(4'd7, 7'd40, 1'b1, 1'b0);
        step(4'd7, 7'd72, 1'b1, 1'b0);
        step(4'd0, 7'd0, 1'b1, 1'b0);
        step(4'd10, 7'd0, 1'b1, 1'b0);
        step(4'd4, 7'd80, 1'b1, 1'b0);
        step(4'd5, 7'd81, 1'b1, 1'b0);
        step(4'd5, 7'd127, 1'b1, 1'b0);
        bd[1] = 4'd10; bd[9] = 4'd15;
        step(4'd5, 7'd0, 1'b1, 1'b0);
        step(4'd3, 7'd0, 1'b0, 1'b0);
        step(4'd3, 7'd0, 1'b0, 1'b0);
        clear_board(); bd[3] = 4'd5;
        step(4'd5, 7'd0, 1'b1, 1'b0);
        step(4'd4, 7'd0, 1'b1, 1'b0);
        step(4'd5, 7'd1, 1'b1, 1'b0);
        step(4'd5, 7'd12, 1'b1, 1'b0);
        step(4'd5, 7'd0, 1'b1, 1'b1);
        step(4'd5, 7'd0, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 81; i++) begin
                int p;
                p = $urandom_range(0, 99);
                bd[i] = p < 60 ? 4'd0 : p < 97 ? 4'($urandom_range(1, 9)) : 4'($urandom_range(10, 15));
            end
            step(4'($urandom_range(0, 99) < 85 ? $urandom_range(1, 9) : $urandom_range(0, 15)),
                 7'($urandom_range(0, 99) < 90 ? $urandom_range(0, 80) : $urandom_range(81, 127)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 49) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
